// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_pkg
// Description : Shared defaults and the sequencer state encoding for one neuron.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  localparam int c_DEFAULT_DW = 8;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    RUN     = 3'd1,
    FLUSH   = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/neuron_sequencer_weight_rf.sv
`default_nettype none
// ============================================================================
// Module      : weight_rf
// Description : N_INPUTS x DW weight register file, one write port and one
//               combinational read port; out-of-range writes match no entry.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_rf
  import neuron_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  parameter  int DW       = c_DEFAULT_DW,
  localparam int AW       = $clog2(N_INPUTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [N_INPUTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (i_wr_en && (i_wr_addr == AW'(i))) r_mem[i] <= i_wr_data;
      end
    end
  end

  // Same-cycle write and read returns the old entry.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/neuron_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : neuron_sequencer
// Description : Streams an input vector into the accumulator with per-index
//               weights and bias, then captures and offers the result.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  parameter  int DW       = c_DEFAULT_DW,
  localparam int AW       = $clog2(N_INPUTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_wr_en,
  input  logic [AW-1:0] w_wr_addr,
  input  logic [DW-1:0] w_wr_data,
  input  logic          bias_wr_en,
  input  logic [DW-1:0] bias_wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [DW-1:0] acc_x,
  output logic [DW-1:0] acc_weight,
  output logic [DW-1:0] acc_bias,
  input  logic [DW-1:0] acc_accu,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  seq_state_e    r_state;
  seq_state_e    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic          w_accept;
  logic          w_last;
  logic [DW-1:0] w_rd_weight;
  logic          r_acc_en;
  logic [DW-1:0] r_acc_x;
  logic [DW-1:0] r_acc_weight;
  logic [DW-1:0] r_bias;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;

  weight_rf #(
    .N_INPUTS (N_INPUTS),
    .DW       (DW)
  ) u_weight_rf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_weight)
  );

  assign w_accept = in_valid && (r_state == RUN);
  assign w_last   = (r_idx == AW'(N_INPUTS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   w_state_nxt = RUN;
      RUN:     if (w_accept && w_last) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = OUT;
      OUT:     if (r_out_valid && out_ready) w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CLEAR;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else if (r_state == CLEAR) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // acc_en follows the accept by one cycle, which also covers the FLUSH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_en     <= 1'b0;
      r_acc_x      <= '0;
      r_acc_weight <= '0;
    end else begin
      r_acc_en <= w_accept;
      if (w_accept) begin
        r_acc_x      <= in_data;
        r_acc_weight <= w_rd_weight;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_bias <= '0;
    else if (bias_wr_en) r_bias <= bias_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_state == CAPTURE) begin
      r_out_valid <= 1'b1;
      r_out_data  <= acc_accu;
    end else if ((r_state == OUT) && r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = (r_state == RUN);
  assign acc_clr    = (r_state == CLEAR);
  assign acc_en     = r_acc_en;
  assign acc_x      = r_acc_x;
  assign acc_weight = r_acc_weight;
  assign acc_bias   = r_bias;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_sequencer
// Description : Directed bench for neuron_sequencer with a behavioural accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              w_wr_en = 1'b0, bias_wr_en = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        [1:0] w_wr_addr = '0;
  logic signed [7:0] w_wr_data = '0, bias_wr_data = '0, in_data = '0;
  logic              in_ready, acc_clr, acc_en, out_valid;
  logic signed [7:0] acc_x, acc_weight, acc_bias, acc_accu, out_data;

  // Behavioural accumulator: sum of x*w plus bias, or a forced value.
  logic signed [15:0] acc_sum;
  logic               acc_force = 1'b0;
  always @(posedge clk) begin
    if (acc_clr)     acc_sum <= '0;
    else if (acc_en) acc_sum <= acc_sum + acc_x * acc_weight;
  end
  assign acc_accu = acc_force ? 8'sh80 : acc_sum[7:0] + acc_bias;

  neuron_sequencer #(.N_INPUTS(4), .DW(8)) u_dut (
    .clk(clk), .rst(rst),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_x(acc_x), .acc_weight(acc_weight),
    .acc_bias(acc_bias), .acc_accu(acc_accu),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Three-input instance: address 3 is representable but out of range.
  logic       w3_en = 1'b0, in3_valid = 1'b0;
  logic [1:0] w3_addr = '0;
  logic [7:0] w3_data = '0, in3_data = '0;
  logic       in3_ready, acc3_clr, acc3_en, out3_valid;
  logic [7:0] acc3_x, acc3_weight, acc3_bias, out3_data;

  neuron_sequencer #(.N_INPUTS(3), .DW(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .w_wr_en(w3_en), .w_wr_addr(w3_addr), .w_wr_data(w3_data),
    .bias_wr_en(1'b0), .bias_wr_data(8'd0),
    .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
    .acc_clr(acc3_clr), .acc_en(acc3_en), .acc_x(acc3_x), .acc_weight(acc3_weight),
    .acc_bias(acc3_bias), .acc_accu(8'd0),
    .out_valid(out3_valid), .out_ready(1'b1), .out_data(out3_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input logic [1:0] a, input logic [7:0] d);
    w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
    step();
    w_wr_en = 1'b0;
  endtask

  // Drive one element; it is accepted at the next edge.
  task automatic send(input logic [7:0] x, input logic [7:0] exp_w, input string tag);
    in_valid = 1'b1; in_data = x;
    step();
    chk({tag, "_en"}, {7'd0, acc_en}, 8'd1);
    chk({tag, "_w"}, acc_weight, exp_w);
    chk({tag, "_x"}, acc_x, x);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_clr",   {7'd0, acc_clr},   8'd1);
    chk("rst_ready", {7'd0, in_ready},  8'd0);
    chk("rst_en",    {7'd0, acc_en},    8'd0);
    chk("rst_ovld",  {7'd0, out_valid}, 8'd0);
    chk("rst_odata", out_data,   8'd0);
    chk("rst_x",     acc_x,      8'd0);
    chk("rst_w",     acc_weight, 8'd0);
    chk("rst_bias",  acc_bias,   8'd0);
    step(); step();
    rst = 1'b1;
    chk("rel_clr", {7'd0, acc_clr}, 8'd1);

    // Test 1: back-to-back vector, weights 1..4, bias 5
    wr_w(2'd0, 8'd1);
    chk("run_ready", {7'd0, in_ready}, 8'd1);
    chk("run_clr",   {7'd0, acc_clr},  8'd0);
    wr_w(2'd1, 8'd2);
    wr_w(2'd2, 8'd3);
    bias_wr_en = 1'b1; bias_wr_data = 8'd5;
    wr_w(2'd3, 8'd4);
    bias_wr_en = 1'b0;
    chk("t1_bias", acc_bias, 8'd5);
    chk("t1_idle_en", {7'd0, acc_en}, 8'd0);
    in_valid = 1'b1; in_data = 8'd1;
    step(); chk("t1_e0_en", {7'd0, acc_en}, 8'd1); chk("t1_e0_w", acc_weight, 8'd1);
    step(); chk("t1_e1_en", {7'd0, acc_en}, 8'd1); chk("t1_e1_w", acc_weight, 8'd2);
    step(); chk("t1_e2_en", {7'd0, acc_en}, 8'd1); chk("t1_e2_w", acc_weight, 8'd3);
    step(); chk("t1_e3_en", {7'd0, acc_en}, 8'd1); chk("t1_e3_w", acc_weight, 8'd4);
    in_valid = 1'b0;
    chk("t1_flush_ready", {7'd0, in_ready}, 8'd0);
    step(); chk("t1_cap_en", {7'd0, acc_en}, 8'd0); chk("t1_cap_ovld", {7'd0, out_valid}, 8'd0);
    step(); chk("t1_ovld", {7'd0, out_valid}, 8'd1); chk("t1_odata", out_data, 8'd15);
    step(); chk("t1_clr", {7'd0, acc_clr}, 8'd1); chk("t1_ovld_drop", {7'd0, out_valid}, 8'd0);
    step();

    // Test 2 + 3: gap of two cycles, then backpressure for five cycles
    out_ready = 1'b0;
    send(8'd1, 8'd1, "t2_e0");
    step(); chk("t2_gap1_en", {7'd0, acc_en}, 8'd0); chk("t2_gap1_w", acc_weight, 8'd1);
    step(); chk("t2_gap2_en", {7'd0, acc_en}, 8'd0);
    send(8'd1, 8'd2, "t2_e1");
    in_valid = 1'b1; send(8'd1, 8'd3, "t2_e2");
    in_valid = 1'b1; send(8'd1, 8'd4, "t2_e3");
    step(); step();
    chk("t2_ovld", {7'd0, out_valid}, 8'd1); chk("t2_odata", out_data, 8'd15);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_ovld",  {7'd0, out_valid}, 8'd1);
      chk("t3_hold_odata", out_data, 8'd15);
      chk("t3_hold_ready", {7'd0, in_ready}, 8'd0);
    end
    out_ready = 1'b1;
    step(); chk("t3_clr", {7'd0, acc_clr}, 8'd1); chk("t3_ovld", {7'd0, out_valid}, 8'd0);
    step();

    // Test 4: overwrite weight[2] in the cycle element 2 is accepted
    send(8'd1, 8'd1, "t4_e0");
    send(8'd2, 8'd2, "t4_e1");
    w_wr_en = 1'b1; w_wr_addr = 2'd2; w_wr_data = -8'sd7;
    send(8'd3, 8'd3, "t4_e2_old");
    w_wr_en = 1'b0;
    send(8'd4, 8'd4, "t4_e3");
    step(); step();
    chk("t4_odata", out_data, 8'd35);
    step(); step();
    send(8'd1, 8'd1, "t4b_e0");
    send(8'd1, 8'd2, "t4b_e1");
    send(8'd1, 8'hF9, "t4b_e2_new");
    send(8'd1, 8'd4, "t4b_e3");
    step(); step();
    chk("t4b_odata", out_data, 8'd5);
    step(); step();

    // Test 5: asynchronous reset at idx=2
    send(8'd1, 8'd1, "t5_e0");
    send(8'd1, 8'd2, "t5_e1");
    chk("t5_pre_en", {7'd0, acc_en}, 8'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_en",   {7'd0, acc_en},    8'd0);
    chk("t5_ovld", {7'd0, out_valid}, 8'd0);
    chk("t5_clr",  {7'd0, acc_clr},   8'd1);
    step();
    rst = 1'b1;
    chk("t5_rel_clr", {7'd0, acc_clr}, 8'd1);
    step();

    // Test 6: zeroed weights after reset, forced -128 result
    send(8'd1, 8'd0, "t6_e0");
    send(8'd1, 8'd0, "t6_e1");
    send(8'd1, 8'd0, "t6_e2");
    send(8'd1, 8'd0, "t6_e3");
    acc_force = 1'b1;
    step(); step();
    chk("t6_odata", out_data, 8'h80);
    acc_force = 1'b0;

    // Out-of-range write on the three-input instance
    w3_en = 1'b1;
    w3_addr = 2'd0; w3_data = 8'd11; step();
    w3_addr = 2'd1; w3_data = 8'd22; step();
    w3_addr = 2'd2; w3_data = 8'd33; step();
    w3_addr = 2'd3; w3_data = 8'd99; step();
    w3_en = 1'b0;
    in3_valid = 1'b1; in3_data = 8'd1;
    step(); chk("oor_w0", acc3_weight, 8'd11);
    step(); chk("oor_w1", acc3_weight, 8'd22);
    step(); chk("oor_w2", acc3_weight, 8'd33);
    in3_valid = 1'b0;
    chk("oor_flush_ready", {7'd0, in3_ready}, 8'd0);
    step(); step();
    chk("oor_ovld", {7'd0, out3_valid}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
